// File: rtl/vga_pkg.sv
// Shared VGA constants and enums for the sprite position controller.
//   H_ACTIVE_DEFAULT / V_ACTIVE_DEFAULT : default visible raster size
//   dir_e   : bit index of each request in the sticky request vector
//   state_e : request/apply controller states
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEFAULT = 640;
    localparam int unsigned V_ACTIVE_DEFAULT = 480;
    localparam int unsigned N_DIR            = 5;

    typedef enum logic [2:0] {
        DIR_UP     = 3'd0,
        DIR_DOWN   = 3'd1,
        DIR_LEFT   = 3'd2,
        DIR_RIGHT  = 3'd3,
        DIR_CENTER = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } state_e;

endpackage

// File: rtl/axis_step.sv
// One-axis position step: computes the next coordinate from the current one.
// Ports:
//   i_cur     current coordinate
//   i_inc     step by +STEP
//   i_dec     step by -STEP (cancels i_inc when both set)
//   i_centre  jump to i_max/2, overriding inc/dec
//   i_max     largest legal coordinate
//   o_next    next coordinate (combinational)
//   o_changed o_next differs from i_cur
// Build option: SPRITE_WRAP_EN makes out-of-range results wrap to the
// opposite limit instead of clamping.
module axis_step #(
    parameter int unsigned W    = 10,
    parameter int unsigned STEP = 8
) (
    input  logic [W-1:0] i_cur,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_centre,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_next,
    output logic         o_changed
);

    localparam logic signed [W:0] STEP_S = $signed((W+1)'(STEP));

    logic signed [W:0] w_cur_s;
    logic signed [W:0] w_max_s;
    logic signed [W:0] w_sum;

    // One extra signed bit so both underflow and overflow are visible
    always_comb begin
        w_cur_s = $signed({1'b0, i_cur});
        w_max_s = $signed({1'b0, i_max});
        w_sum   = w_cur_s;
        if (i_inc && !i_dec) begin
            w_sum = w_cur_s + STEP_S;
        end else if (i_dec && !i_inc) begin
            w_sum = w_cur_s - STEP_S;
        end

        o_next = i_cur;
        if (i_centre) begin
            o_next = i_max >> 1;
        end else if (w_sum[W]) begin
`ifdef SPRITE_WRAP_EN
            o_next = i_max;
`else
            o_next = '0;
`endif
        end else if (w_sum > w_max_s) begin
`ifdef SPRITE_WRAP_EN
            o_next = '0;
`else
            o_next = i_max;
`endif
        end else begin
            o_next = w_sum[W-1:0];
        end

        o_changed = (o_next != i_cur);
    end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: latches button pulses during a frame and
// applies them once per frame at frame_start so the sprite never tears.
// Ports:
//   clk, clr_n                      clock, async active-low reset
//   up_p/down_p/left_p/right_p      one-cycle move pulses
//   center_p                        one-cycle recentre pulse
//   frame_start                     one-cycle pulse at start of vblank
//   x_pos, y_pos                    sprite top-left corner
//   pending                         requests latched, not yet applied
//   moved                           one-cycle pulse when position changed
//   edge_x, edge_y                  position at an axis limit (combinational)
// Build option: SPRITE_WRAP_EN selects wrap instead of clamp at the limits.
module sprite_pos_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int unsigned SPR_W    = 16,
    parameter int unsigned SPR_H    = 16,
    parameter int unsigned STEP     = 8,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          up_p,
    input  logic          down_p,
    input  logic          left_p,
    input  logic          right_p,
    input  logic          center_p,
    input  logic          frame_start,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic          pending,
    output logic          moved,
    output logic          edge_x,
    output logic          edge_y
);

    localparam int unsigned X_MAX   = H_ACTIVE - SPR_W;
    localparam int unsigned Y_MAX   = V_ACTIVE - SPR_H;
    localparam logic [XW-1:0] X_MAX_V = XW'(X_MAX);
    localparam logic [YW-1:0] Y_MAX_V = YW'(Y_MAX);
    localparam logic [XW-1:0] X_MID_V = XW'(X_MAX / 2);
    localparam logic [YW-1:0] Y_MID_V = YW'(Y_MAX / 2);

    state_e            r_state;
    state_e            w_state_nx;
    logic [N_DIR-1:0]  w_pulses;
    logic [N_DIR-1:0]  r_sticky;
    logic [N_DIR-1:0]  w_sticky_nx;
    logic [N_DIR-1:0]  r_apply;
    logic [N_DIR-1:0]  w_apply_nx;
    logic [XW-1:0]     r_x;
    logic [XW-1:0]     w_x_nx;
    logic [YW-1:0]     r_y;
    logic [YW-1:0]     w_y_nx;
    logic              w_x_chg;
    logic              w_y_chg;
    logic              r_pending;
    logic              r_moved;

    // Gather request pulses into a direction-indexed vector
    always_comb begin
        w_pulses             = '0;
        w_pulses[DIR_UP]     = up_p;
        w_pulses[DIR_DOWN]   = down_p;
        w_pulses[DIR_LEFT]   = left_p;
        w_pulses[DIR_RIGHT]  = right_p;
        w_pulses[DIR_CENTER] = center_p;
    end

    // Next-state logic; at frame_start the sticky set moves into the apply
    // register and restarts with only the pulses of that same cycle
    always_comb begin
        w_state_nx  = r_state;
        w_sticky_nx = r_sticky | w_pulses;
        w_apply_nx  = r_apply;
        case (r_state)
            IDLE: begin
                if (|w_pulses) begin
                    w_state_nx = ARMED;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    w_state_nx  = APPLY;
                    w_apply_nx  = r_sticky;
                    w_sticky_nx = w_pulses;
                end
            end
            APPLY: begin
                w_apply_nx = '0;
                w_state_nx = (|w_sticky_nx) ? ARMED : IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // y grows downward, so "down" increments and "up" decrements
    axis_step #(.W(XW), .STEP(STEP)) u_axis_x (
        .i_cur     (r_x),
        .i_inc     (r_apply[DIR_RIGHT]),
        .i_dec     (r_apply[DIR_LEFT]),
        .i_centre  (r_apply[DIR_CENTER]),
        .i_max     (X_MAX_V),
        .o_next    (w_x_nx),
        .o_changed (w_x_chg)
    );

    axis_step #(.W(YW), .STEP(STEP)) u_axis_y (
        .i_cur     (r_y),
        .i_inc     (r_apply[DIR_DOWN]),
        .i_dec     (r_apply[DIR_UP]),
        .i_centre  (r_apply[DIR_CENTER]),
        .i_max     (Y_MAX_V),
        .o_next    (w_y_nx),
        .o_changed (w_y_chg)
    );

    // State, request and position registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= IDLE;
            r_sticky  <= '0;
            r_apply   <= '0;
            r_x       <= X_MID_V;
            r_y       <= Y_MID_V;
            r_pending <= 1'b0;
            r_moved   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sticky  <= w_sticky_nx;
            r_apply   <= w_apply_nx;
            r_pending <= (w_state_nx != IDLE);
            r_moved   <= 1'b0;
            if (r_state == APPLY) begin
                r_x     <= w_x_nx;
                r_y     <= w_y_nx;
                r_moved <= w_x_chg | w_y_chg;
            end
        end
    end

    assign x_pos   = r_x;
    assign y_pos   = r_y;
    assign pending = r_pending;
    assign moved   = r_moved;
    assign edge_x  = (r_x == '0) || (r_x == X_MAX_V);
    assign edge_y  = (r_y == '0) || (r_y == Y_MAX_V);

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Self-checking bench for sprite_pos_ctrl. Expected positions are queued
// when a frame is issued and popped by a monitor whenever moved is seen.
// Honours SPRITE_WRAP_EN for the limit-crossing expectation.
module tb_sprite_pos_ctrl;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

    localparam logic [5:0] M_UP    = 6'b000001;
    localparam logic [5:0] M_DOWN  = 6'b000010;
    localparam logic [5:0] M_LEFT  = 6'b000100;
    localparam logic [5:0] M_RIGHT = 6'b001000;
    localparam logic [5:0] M_CTR   = 6'b010000;
    localparam logic [5:0] M_FS    = 6'b100000;
    localparam logic [5:0] M_NONE  = 6'b000000;

    logic       clk;
    logic       clr_n;
    logic       up_p, down_p, left_p, right_p, center_p, frame_start;
    logic [9:0] x_pos, y_pos;
    logic       pending, moved, edge_x, edge_y;

    pos_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   cx;
    int   cy;

    sprite_pos_ctrl dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .up_p        (up_p),
        .down_p      (down_p),
        .left_p      (left_p),
        .right_p     (right_p),
        .center_p    (center_p),
        .frame_start (frame_start),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pending     (pending),
        .moved       (moved),
        .edge_x      (edge_x),
        .edge_y      (edge_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive a set of pulses for exactly one clock
    task automatic pulse(input logic [5:0] m);
        {frame_start, center_p, right_p, left_p, down_p, up_p} = m;
        @(posedge clk);
        #1;
        {frame_start, center_p, right_p, left_p, down_p, up_p} = 6'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        pulse(M_FS);
        idle(3);
    endtask

    // Request m, then apply it on a frame; queue a move only if position changes
    task automatic move(input logic [5:0] m, input int nx, input int ny);
        pulse(m);
        idle(1);
        if (nx != cx || ny != cy) begin
            exp_q.push_back({10'(nx), 10'(ny)});
        end
        cx = nx;
        cy = ny;
        frame();
        check("pos_x", 32'(x_pos), 32'(nx));
        check("pos_y", 32'(y_pos), 32'(ny));
        check("pending_clear", 32'(pending), 32'd0);
    endtask

    // Scoreboard monitor: every moved pulse must match the oldest expectation
    always @(negedge clk) begin
        pos_t e;
        if (clr_n === 1'b1 && moved === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon_unexpected_move: got x=%0d y=%0d, expected no move", x_pos, y_pos);
            end else begin
                e = exp_q.pop_front();
                check("mon_x", 32'(x_pos), 32'(e.x));
                check("mon_y", 32'(y_pos), 32'(e.y));
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cx      = 312;
        cy      = 232;
        clr_n   = 1'b0;
        {frame_start, center_p, right_p, left_p, down_p, up_p} = 6'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x", 32'(x_pos), 32'd312);
        check("rst_y", 32'(y_pos), 32'd232);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_moved", 32'(moved), 32'd0);
        check("rst_edge_x", 32'(edge_x), 32'd0);
        check("rst_edge_y", 32'(edge_y), 32'd0);
        clr_n = 1'b1;
        idle(2);

        // Opposing directions cancel
        pulse(M_LEFT | M_RIGHT);
        @(negedge clk);
        check("lr_pending", 32'(pending), 32'd1);
        frame();
        check("lr_x", 32'(x_pos), 32'd312);
        check("lr_pending_clear", 32'(pending), 32'd0);

        // Single right step with latency check
        idle(5);
        pulse(M_RIGHT);
        @(negedge clk);
        check("r_pending", 32'(pending), 32'd1);
        idle(10);
        exp_q.push_back({10'd320, 10'd232});
        cx = 320;
        pulse(M_FS);
        @(negedge clk);
        check("r_x_during_apply", 32'(x_pos), 32'd312);
        check("r_moved_during_apply", 32'(moved), 32'd0);
        @(negedge clk);
        check("r_x_after_apply", 32'(x_pos), 32'd320);
        check("r_moved_pulse", 32'(moved), 32'd1);
        @(negedge clk);
        check("r_moved_one_cycle", 32'(moved), 32'd0);
        check("r_y_unchanged", 32'(y_pos), 32'd232);
        check("r_pending_clear", 32'(pending), 32'd0);
        idle(1);

        // Repeated pulses of one direction give one step
        pulse(M_RIGHT);
        pulse(M_RIGHT);
        move(M_RIGHT, 328, 232);

        // March to 616, then to the right limit
        for (int i = 0; i < 36; i++) begin
            move(M_RIGHT, cx + 8, cy);
        end
        check("x616_edge", 32'(edge_x), 32'd0);
        move(M_RIGHT, 624, 232);
        check("xmax_edge", 32'(edge_x), 32'd1);
`ifdef SPRITE_WRAP_EN
        move(M_RIGHT, 0, 232);
`else
        move(M_RIGHT, 624, 232);
`endif
        check("xlimit_edge", 32'(edge_x), 32'd1);
        check("xlimit_edge_y", 32'(edge_y), 32'd0);

        // Centre overrides other directions
        move(M_CTR | M_LEFT | M_DOWN, 312, 232);

        // Pulse coinciding with frame_start while idle is deferred
        pulse(M_UP | M_FS);
        idle(3);
        check("upfs_y", 32'(y_pos), 32'd232);
        check("upfs_pending", 32'(pending), 32'd1);
        move(M_NONE, 312, 224);

        // New pulse on the frame_start cycle while armed goes to next frame
        pulse(M_DOWN);
        idle(1);
        exp_q.push_back({10'd312, 10'd232});
        cy = 232;
        pulse(M_FS | M_LEFT);
        idle(3);
        check("defer_y", 32'(y_pos), 32'd232);
        check("defer_x", 32'(x_pos), 32'd312);
        check("defer_pending", 32'(pending), 32'd1);
        move(M_NONE, 304, 232);

        // Reset mid-operation discards the pending request
        pulse(M_RIGHT);
        idle(1);
        check("rst_mid_pending_before", 32'(pending), 32'd1);
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        check("rst_mid_pending", 32'(pending), 32'd0);
        check("rst_mid_x", 32'(x_pos), 32'd312);
        check("rst_mid_y", 32'(y_pos), 32'd232);
        clr_n = 1'b1;
        cx = 312;
        idle(2);
        frame();
        check("rst_mid_no_move_x", 32'(x_pos), 32'd312);
        check("rst_mid_no_pending", 32'(pending), 32'd0);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
